// File: rtl/obj_manager_if.sv
// Spawn/clear handshake bundle between the game controller (master) and obj_manager (slave).
interface obj_manager_if;
    logic       spawn_valid;
    logic [1:0] spawn_type;
    logic [9:0] spawn_y;
    logic       spawn_ready;
    logic       clear_valid;
    logic [2:0] clear_slot;

    modport master (
        output spawn_valid, spawn_type, spawn_y, clear_valid, clear_slot,
        input  spawn_ready
    );

    modport slave (
        input  spawn_valid, spawn_type, spawn_y, clear_valid, clear_slot,
        output spawn_ready
    );
endinterface

// File: rtl/obj_manager.sv
// Five-slot scrolling object table with per-frame animation, spawn and clear handshakes.
// Define OBJ_MANAGER_STATS_EN to add saturating spawn_count/drop_count outputs.
module obj_manager #(
    parameter int unsigned FRAME_DIV = 8,
    parameter int unsigned SPAWN_X   = 1023
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          vsync,
    input  logic          pause,
    input  logic [3:0]    speed,
    obj_manager_if.slave  req,
    output logic [25:0]   obj1,
    output logic [25:0]   obj2,
    output logic [25:0]   obj3,
    output logic [25:0]   obj4,
    output logic [25:0]   obj5,
    output logic [4:0]    active,
    output logic          frame_tick
`ifdef OBJ_MANAGER_STATS_EN
    ,
    output logic [15:0]   spawn_count,
    output logic [15:0]   drop_count
`endif
);
    localparam int unsigned NumSlots = 5;
    localparam logic [10:0] SpawnX   = 11'(SPAWN_X);
    localparam logic [3:0]  AnimLast = 4'(FRAME_DIV - 1);
    localparam logic [9:0]  YMax     = 10'd767;

    logic [25:0] slot_q [NumSlots];
    logic [25:0] slot_d [NumSlots];
    logic [4:0]  active_q, active_d;
    logic [3:0]  anim_q, anim_d;
    logic        vsync_q, frame_tick_q;
    logic        tick, anim_wrap, accept;
    logic [4:0]  spawn_onehot;
    logic [9:0]  spawn_y_clamped;

    assign tick            = vsync_q & ~vsync & ~pause;
    assign anim_wrap       = tick & (anim_q == AnimLast);
    assign req.spawn_ready = reset & (active_q != 5'b11111) & ~tick;
    assign accept          = req.spawn_valid & req.spawn_ready;
    assign spawn_y_clamped = (req.spawn_y > YMax) ? YMax : req.spawn_y;

    // Descending scan so the lowest free index is the last one written.
    always_comb begin
        spawn_onehot = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (!active_q[i]) begin
                spawn_onehot    = '0;
                spawn_onehot[i] = 1'b1;
            end
        end
    end

    // Priority per slot: scroll, then clear overrides, then spawn (only into slots free before).
    always_comb begin
        slot_d   = slot_q;
        active_d = active_q;
        anim_d   = anim_q;
        if (tick) begin
            anim_d = anim_wrap ? 4'd0 : anim_q + 4'd1;
        end
        for (int i = 0; i < NumSlots; i++) begin
            if (tick && active_q[i]) begin
                if (slot_q[i][20:10] < {7'd0, speed}) begin
                    slot_d[i]   = '0;
                    active_d[i] = 1'b0;
                end else begin
                    slot_d[i][20:10] = slot_q[i][20:10] - {7'd0, speed};
                    if (anim_wrap) begin
                        slot_d[i][25:23] = slot_q[i][25:23] + 3'd1;
                    end
                end
            end
            if (req.clear_valid && (req.clear_slot == 3'(i))) begin
                slot_d[i]   = '0;
                active_d[i] = 1'b0;
            end
            if (accept && spawn_onehot[i]) begin
                slot_d[i]   = {3'b000, req.spawn_type, SpawnX, spawn_y_clamped};
                active_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NumSlots; i++) begin
                slot_q[i] <= '0;
            end
            active_q     <= '0;
            anim_q       <= '0;
            vsync_q      <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            active_q     <= active_d;
            anim_q       <= anim_d;
            vsync_q      <= vsync;
            frame_tick_q <= tick;
        end
    end

    assign obj1       = slot_q[0];
    assign obj2       = slot_q[1];
    assign obj3       = slot_q[2];
    assign obj4       = slot_q[3];
    assign obj5       = slot_q[4];
    assign active     = active_q;
    assign frame_tick = frame_tick_q;

`ifdef OBJ_MANAGER_STATS_EN
    logic [15:0] spawn_cnt_q, spawn_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [2:0]  drop_num;
    logic [16:0] drop_sum;

    // A slot cleared on the tick cycle is not counted as a scroll-off.
    always_comb begin
        drop_num = '0;
        for (int i = 0; i < NumSlots; i++) begin
            if (tick && active_q[i] && (slot_q[i][20:10] < {7'd0, speed}) &&
                !(req.clear_valid && (req.clear_slot == 3'(i)))) begin
                drop_num = drop_num + 3'd1;
            end
        end
        drop_sum    = {1'b0, drop_cnt_q} + {14'd0, drop_num};
        drop_cnt_d  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        spawn_cnt_d = (accept && (spawn_cnt_q != 16'hFFFF)) ? spawn_cnt_q + 16'd1 : spawn_cnt_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            spawn_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            spawn_cnt_q <= spawn_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign spawn_count = spawn_cnt_q;
    assign drop_count  = drop_cnt_q;
`endif
endmodule

// File: tb/tb_obj_manager.sv
// Directed bench for obj_manager: expected values are queued as stimulus is driven and
// popped when the corresponding DUT output is sampled.
module tb_obj_manager;
    logic        clock = 1'b0;
    logic        reset;
    logic        vsync;
    logic        pause;
    logic [3:0]  speed;
    logic [25:0] obj1, obj2, obj3, obj4, obj5;
    logic [4:0]  active;
    logic        frame_tick;
`ifdef OBJ_MANAGER_STATS_EN
    logic [15:0] spawn_count, drop_count;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [25:0] exp;
    } exp_t;
    exp_t sb[$];

    obj_manager_if bus ();

    obj_manager #(
        .FRAME_DIV (8),
        .SPAWN_X   (1023)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .vsync      (vsync),
        .pause      (pause),
        .speed      (speed),
        .req        (bus),
        .obj1       (obj1),
        .obj2       (obj2),
        .obj3       (obj3),
        .obj4       (obj4),
        .obj5       (obj5),
        .active     (active),
        .frame_tick (frame_tick)
`ifdef OBJ_MANAGER_STATS_EN
        ,
        .spawn_count (spawn_count),
        .drop_count  (drop_count)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [25:0] desc(int f, int t, int x, int y);
        return {3'(f), 2'(t), 11'(x), 10'(y)};
    endfunction

    function automatic logic [25:0] obj_by(int i);
        case (i)
            0:       return obj1;
            1:       return obj2;
            2:       return obj3;
            3:       return obj4;
            default: return obj5;
        endcase
    endfunction

    task automatic push(string tag, logic [25:0] e);
        exp_t item;
        item.tag = tag;
        item.exp = e;
        sb.push_back(item);
    endtask

    task automatic chk(logic [25:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: got %h expected nothing queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: got %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic tick_pulse();
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b0; vsync = 1'b0; pause = 1'b0; speed = 4'd0;
        bus.spawn_valid = 1'b0; bus.spawn_type = 2'd0; bus.spawn_y = 10'd0;
        bus.clear_valid = 1'b0; bus.clear_slot = 3'd0;

        settle();
        push("rst_ready", 26'd0); chk(26'(bus.spawn_ready));
        step(); step();
        push("rst_active", 26'd0); push("rst_obj1", 26'd0); push("rst_ftick", 26'd0);
        chk(26'(active)); chk(obj1); chk(26'(frame_tick));
        reset = 1'b1;
        step();

        // First spawn lands in slot 1
        bus.spawn_valid = 1'b1; bus.spawn_type = 2'd2; bus.spawn_y = 10'd300;
        settle();
        push("spawn_ready", 26'd1); chk(26'(bus.spawn_ready));
        push("spawn_obj1", desc(0, 2, 1023, 300)); push("spawn_active", 26'd1);
        step();
        bus.spawn_valid = 1'b0;
        chk(obj1); chk(26'(active));

        // Scrolling and animation
        speed = 4'd4;
        tick_pulse();
        push("ftick_on", 26'd1); chk(26'(frame_tick));
        push("ftick_off", 26'd0);
        step();
        chk(26'(frame_tick));
        for (int i = 0; i < 6; i++) tick_pulse();
        push("x_7ticks", desc(0, 2, 995, 300)); chk(obj1);
        tick_pulse();
        push("frame_8ticks", desc(1, 2, 991, 300)); chk(obj1);
        tick_pulse(); tick_pulse();
        push("x_10ticks", desc(1, 2, 983, 300)); chk(obj1);

        // Pause suppresses the tick
        pause = 1'b1;
        vsync = 1'b1; step(); vsync = 1'b0; step();
        push("pause_obj1", desc(1, 2, 983, 300)); push("pause_ftick", 26'd0);
        chk(obj1); chk(26'(frame_tick));
        pause = 1'b0;
        step();

        // Spawn held across the tick cycle, with y clamp
        vsync = 1'b1; step(); vsync = 1'b0;
        bus.spawn_valid = 1'b1; bus.spawn_type = 2'd1; bus.spawn_y = 10'd900;
        settle();
        push("ready_on_tick", 26'd0); chk(26'(bus.spawn_ready));
        push("tick_no_accept", 26'd1); push("x_11ticks", desc(1, 2, 979, 300));
        step();
        chk(26'(active)); chk(obj1);
        settle();
        push("ready_after_tick", 26'd1); chk(26'(bus.spawn_ready));
        push("held_accept_obj2", desc(0, 1, 1023, 767)); push("held_accept_active", 26'd3);
        step();
        bus.spawn_valid = 1'b0;
        chk(obj2); chk(26'(active));

        // Out-of-range clear is ignored
        bus.clear_valid = 1'b1; bus.clear_slot = 3'd6;
        push("clr6_active", 26'd3); push("clr6_obj1", desc(1, 2, 979, 300));
        push("clr6_obj2", desc(0, 1, 1023, 767));
        step();
        bus.clear_valid = 1'b0;
        chk(26'(active)); chk(obj1); chk(obj2);

        // Reset during a pending spawn
        reset = 1'b0;
        bus.spawn_valid = 1'b1; bus.spawn_type = 2'd3; bus.spawn_y = 10'd5;
        settle();
        push("ready_in_reset", 26'd0); chk(26'(bus.spawn_ready));
        push("reset_active", 26'd0); push("reset_obj2", 26'd0);
        step();
        chk(26'(active)); chk(obj2);
        reset = 1'b1;

        // Back-to-back spawns fill slots 1..5
        for (int i = 0; i < 5; i++) begin
            bus.spawn_type = 2'(i % 4);
            bus.spawn_y    = 10'(10 * i + 1);
            settle();
            push("fill_ready", 26'd1); chk(26'(bus.spawn_ready));
            push("fill_obj", desc(0, i % 4, 1023, 10 * i + 1));
            step();
            chk(obj_by(i));
        end
        settle();
        push("full_ready", 26'd0); chk(26'(bus.spawn_ready));
        push("full_active", 26'd31); chk(26'(active));
        bus.spawn_type = 2'd3; bus.spawn_y = 10'd555;
        push("held_obj3", desc(0, 2, 1023, 21)); push("held_active", 26'd31);
        step(); step();
        chk(obj3); chk(26'(active));
        bus.clear_valid = 1'b1; bus.clear_slot = 3'd2;
        push("clr2_active", 26'd27); push("clr2_obj3", 26'd0);
        step();
        bus.clear_valid = 1'b0;
        chk(26'(active)); chk(obj3);
        settle();
        push("refill_ready", 26'd1); chk(26'(bus.spawn_ready));
        push("refill_obj3", desc(0, 3, 1023, 555)); push("refill_active", 26'd31);
        step();
        bus.spawn_valid = 1'b0;
        chk(obj3); chk(26'(active));

        // Clear and spawn together: cleared slot is not reused this cycle
        bus.clear_valid = 1'b1; bus.clear_slot = 3'd4;
        push("clr4_active", 26'd15);
        step();
        chk(26'(active));
        bus.clear_slot = 3'd0;
        bus.spawn_valid = 1'b1; bus.spawn_type = 2'd1; bus.spawn_y = 10'd42;
        push("cs_obj5", desc(0, 1, 1023, 42)); push("cs_obj1", 26'd0); push("cs_active", 26'd30);
        step();
        bus.clear_valid = 1'b0; bus.spawn_valid = 1'b0;
        chk(obj5); chk(obj1); chk(26'(active));

        // Clear on the tick cycle, then scroll-off
        reset = 1'b0; step(); reset = 1'b1;
        bus.spawn_valid = 1'b1; bus.spawn_type = 2'd0; bus.spawn_y = 10'd100;
        step();
        bus.spawn_type = 2'd3; bus.spawn_y = 10'd200;
        step();
        bus.spawn_valid = 1'b0;
        speed = 4'd15;
        vsync = 1'b1; step(); vsync = 1'b0;
        bus.clear_valid = 1'b1; bus.clear_slot = 3'd1;
        push("tc_obj1", desc(0, 0, 1008, 100)); push("tc_obj2", 26'd0); push("tc_active", 26'd1);
        step();
        bus.clear_valid = 1'b0;
        chk(obj1); chk(obj2); chk(26'(active));
        for (int i = 0; i < 67; i++) tick_pulse();
        push("x_at_3", desc(0, 0, 3, 100)); chk(obj1);
        speed = 4'd4;
        tick_pulse();
        push("scroll_off_obj1", 26'd0); push("scroll_off_active", 26'd0);
        chk(obj1); chk(26'(active));
`ifdef OBJ_MANAGER_STATS_EN
        push("spawn_count", 26'd2); push("drop_count", 26'd1);
        chk(26'(spawn_count)); chk(26'(drop_count));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
